ldo_test_pattern_gen: RTL and testbench

Sequencer that drives the LDO test-override interface: the ldotop_en / ldotop_test_in[31:0] pair that bypasses the closed-loop controller and sets the pass-transistor gates directly.
- Generates thermometer codes as hold, ramp, triangle or step patterns, with a programmable dwell per level.
- Releases the override when the pattern finishes, returning the regulator to closed-loop control.
- Sits beside the LDO top, clocked from the same clk as the controller logic.

---
 rtl/ldo_test_pattern_gen_pkg.sv | 37 +++
 rtl/ldo_test_pattern_gen_if.sv | 35 +++
 rtl/ldo_test_pattern_gen_therm_enc.sv | 22 ++
 rtl/ldo_test_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_ldo_test_pattern_gen.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ldo_test_pattern_gen_pkg.sv
// ----------------------------------------------------------------------------
// ldo_test_pkg
// Shared definitions for the LDO test-override pattern generator:
//   - sizing: N_LEGS (pass-transistor legs), CNT_W (level width), DWELL_W
//   - pattern mode encodings carried on cfg_mode
//   - sequencer state enum
//   - level clamp and mode-validity helpers
// ----------------------------------------------------------------------------
package ldo_test_pkg;

    localparam int N_LEGS  = 32;
    localparam int CNT_W   = 6;
    localparam int DWELL_W = 16;

    localparam logic [2:0] MODE_HOLD      = 3'd0;
    localparam logic [2:0] MODE_RAMP_UP   = 3'd1;
    localparam logic [2:0] MODE_RAMP_DOWN = 3'd2;
    localparam logic [2:0] MODE_TRIANGLE  = 3'd3;
    localparam logic [2:0] MODE_STEP      = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A level can never exceed the number of legs.
    function automatic logic [CNT_W-1:0] clamp_lvl(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(N_LEGS)) ? CNT_W'(N_LEGS) : v;
    endfunction

    // Modes 5..7 are reserved.
    function automatic logic mode_valid(input logic [2:0] m);
        return (m <= MODE_STEP);
    endfunction

endpackage

// File: rtl/ldo_test_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// ldo_test_pattern_gen_if
// Control/config and override-output bundle of the pattern generator.
//   master : test controller side (drives start/stop/cfg_*, observes outputs)
//   slave  : generator side
// Signals: start, stop, cfg_mode[2:0], cfg_lo, cfg_hi, cfg_dwell,
//          test_en, test_code[N_LEGS-1:0], cur_count, busy, done, err
// ----------------------------------------------------------------------------
interface ldo_test_pattern_gen_if;
    import ldo_test_pkg::*;

    logic                start;
    logic                stop;
    logic [2:0]          cfg_mode;
    logic [CNT_W-1:0]    cfg_lo;
    logic [CNT_W-1:0]    cfg_hi;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic                test_en;
    logic [N_LEGS-1:0]   test_code;
    logic [CNT_W-1:0]    cur_count;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, stop, cfg_mode, cfg_lo, cfg_hi, cfg_dwell,
        input  test_en, test_code, cur_count, busy, done, err
    );

    modport slave (
        input  start, stop, cfg_mode, cfg_lo, cfg_hi, cfg_dwell,
        output test_en, test_code, cur_count, busy, done, err
    );

endinterface

// File: rtl/ldo_test_pattern_gen_therm_enc.sv
// ----------------------------------------------------------------------------
// ldo_therm_enc
// Combinational level-to-thermometer encoder: code_o = (1 << count_i) - 1,
// i.e. the lowest count_i legs are on. count_i = N_LEGS gives all ones.
//   count_i : level, CNT_W bits
//   code_o  : thermometer code, N_LEGS bits
// ----------------------------------------------------------------------------
module ldo_therm_enc
    import ldo_test_pkg::*;
(
    input  logic [CNT_W-1:0]  count_i,
    output logic [N_LEGS-1:0] code_o
);

    always_comb begin
        code_o = '0;
        for (int i = 0; i < N_LEGS; i++) begin
            code_o[i] = (count_i > CNT_W'(i));
        end
    end

endmodule

// File: rtl/ldo_test_pattern_gen.sv
// ----------------------------------------------------------------------------
// ldo_test_pattern_gen
// Sequencer for the LDO test override (ldotop_en / ldotop_test_in). Plays
// hold, ramp-up, ramp-down, triangle or step patterns of thermometer codes,
// each level held for a programmable dwell, and drops the override when the
// pattern ends or is aborted so the regulator returns to closed loop.
//   clk : controller clock
//   rst : asynchronous, active-high reset
//   tp  : slave modport -- start/stop/cfg_* in; test_en, test_code,
//         cur_count, busy, done, err out (all registered)
// ----------------------------------------------------------------------------
module ldo_test_pattern_gen
    import ldo_test_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    ldo_test_pattern_gen_if.slave   tp
);

    state_t              state_q;
    logic [2:0]          mode_q;
    logic [CNT_W-1:0]    lo_q, hi_q;
    logic [DWELL_W-1:0]  dwell_q, dwell_cnt_q;
    logic [CNT_W-1:0]    cur_q, cur_d;
    logic                dir_up_q, dir_up_d;
    logic                step_hi_q, step_hi_d;
    logic                test_en_q, busy_q, done_q, err_q;
    logic [N_LEGS-1:0]   code_q, code_d;

    logic [CNT_W-1:0]    lo_c, hi_c, lo_new, hi_new;
    logic [DWELL_W-1:0]  dwell_new;
    logic                accept, adv, fin;

    // Config conditioning: clamp, order, and never allow a zero dwell.
    assign lo_c      = clamp_lvl(tp.cfg_lo);
    assign hi_c      = clamp_lvl(tp.cfg_hi);
    assign lo_new    = (lo_c > hi_c) ? hi_c : lo_c;
    assign hi_new    = (lo_c > hi_c) ? lo_c : hi_c;
    assign dwell_new = (tp.cfg_dwell == '0) ? DWELL_W'(1) : tp.cfg_dwell;

    assign accept = (state_q == ST_IDLE) && tp.start && mode_valid(tp.cfg_mode);
    assign adv    = (dwell_cnt_q == '0);

    // Next level. The code register is loaded from the encoded next level so
    // test_code and cur_count always change on the same edge.
    always_comb begin
        cur_d     = cur_q;
        dir_up_d  = dir_up_q;
        step_hi_d = step_hi_q;
        fin       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cur_d = '0;
                if (accept) begin
                    cur_d     = (tp.cfg_mode == MODE_RAMP_DOWN) ? hi_new : lo_new;
                    dir_up_d  = 1'b1;
                    step_hi_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (tp.stop) begin
                    fin = 1'b1;
                end else if (adv) begin
                    case (mode_q)
                        MODE_RAMP_UP: begin
                            if (cur_q == hi_q) fin = 1'b1;
                            else               cur_d = cur_q + CNT_W'(1);
                        end
                        MODE_RAMP_DOWN: begin
                            if (cur_q == lo_q) fin = 1'b1;
                            else               cur_d = cur_q - CNT_W'(1);
                        end
                        MODE_TRIANGLE: begin
                            // Turn around without repeating the endpoint.
                            if (lo_q != hi_q) begin
                                if (dir_up_q) begin
                                    if (cur_q == hi_q) begin
                                        cur_d    = cur_q - CNT_W'(1);
                                        dir_up_d = 1'b0;
                                    end else begin
                                        cur_d = cur_q + CNT_W'(1);
                                    end
                                end else begin
                                    if (cur_q == lo_q) begin
                                        cur_d    = cur_q + CNT_W'(1);
                                        dir_up_d = 1'b1;
                                    end else begin
                                        cur_d = cur_q - CNT_W'(1);
                                    end
                                end
                            end
                        end
                        MODE_STEP: begin
                            step_hi_d = ~step_hi_q;
                            cur_d     = step_hi_q ? lo_q : hi_q;
                        end
                        default: cur_d = cur_q;   // HOLD
                    endcase
                end
                if (fin) cur_d = '0;
            end
            default: cur_d = '0;
        endcase
    end

    ldo_therm_enc u_enc (
        .count_i (cur_d),
        .code_o  (code_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_HOLD;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            cur_q       <= '0;
            dir_up_q    <= 1'b1;
            step_hi_q   <= 1'b0;
            code_q      <= '0;
            test_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            code_q    <= code_d;
            dir_up_q  <= dir_up_d;
            step_hi_q <= step_hi_d;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_RUN;
                        mode_q      <= tp.cfg_mode;
                        lo_q        <= lo_new;
                        hi_q        <= hi_new;
                        dwell_q     <= dwell_new;
                        dwell_cnt_q <= dwell_new - DWELL_W'(1);
                        test_en_q   <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (tp.start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fin) begin
                        state_q   <= ST_DONE;
                        test_en_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (adv) begin
                        dwell_cnt_q <= dwell_q - DWELL_W'(1);
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    test_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign tp.test_en   = test_en_q;
    assign tp.test_code = code_q;
    assign tp.cur_count = cur_q;
    assign tp.busy      = busy_q;
    assign tp.done      = done_q;
    assign tp.err       = err_q;

endmodule

// File: tb/tb_ldo_test_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_ldo_test_pattern_gen
// Scoreboard bench: stimulus pushes the expected per-cycle output records,
// a negedge monitor pops and compares whenever the generator is active.
// ----------------------------------------------------------------------------
module tb_ldo_test_pattern_gen;
    import ldo_test_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ldo_test_pattern_gen_if tp ();

    ldo_test_pattern_gen dut (
        .clk (clk),
        .rst (rst),
        .tp  (tp)
    );

    typedef struct packed {
        logic        en;
        logic [31:0] code;
        logic [5:0]  cnt;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t run_rec(input logic [31:0] code, input logic [5:0] cnt);
        return '{en: 1'b1, code: code, cnt: cnt, busy: 1'b1, done: 1'b0, err: 1'b0};
    endfunction

    function automatic exp_t done_rec();
        return '{en: 1'b0, code: 32'h0, cnt: 6'd0, busy: 1'b1, done: 1'b1, err: 1'b0};
    endfunction

    // Monitor: any active output cycle must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (tp.test_en || tp.busy || tp.done || tp.err)) begin
            exp_t act;
            exp_t e;
            act = '{en: tp.test_en, code: tp.test_code, cnt: tp.cur_count,
                    busy: tp.busy, done: tp.done, err: tp.err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output t=%0t act en=%0b code=%h cnt=%0d busy=%0b done=%0b err=%0b req none",
                         $time, act.en, act.code, act.cnt, act.busy, act.done, act.err);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL out_seq t=%0t act en=%0b code=%h cnt=%0d busy=%0b done=%0b err=%0b req en=%0b code=%h cnt=%0d busy=%0b done=%0b err=%0b",
                             $time, act.en, act.code, act.cnt, act.busy, act.done, act.err,
                             e.en, e.code, e.cnt, e.busy, e.done, e.err);
                end
            end
        end
    end

    task automatic chk_now(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // Returns in the first cycle after the start was sampled.
    task automatic launch(input logic [2:0] m, input logic [5:0] lo, input logic [5:0] hi,
                          input logic [15:0] dw, input logic with_stop);
        @(posedge clk); #1;
        tp.start     = 1'b1;
        tp.stop      = with_stop;
        tp.cfg_mode  = m;
        tp.cfg_lo    = lo;
        tp.cfg_hi    = hi;
        tp.cfg_dwell = dw;
        @(posedge clk); #1;
        tp.start = 1'b0;
        tp.stop  = 1'b0;
    endtask

    // Called in run cycle 1; raises stop during run cycle k.
    task automatic stop_at(input int k);
        if (k > 1) begin
            repeat (k - 1) @(posedge clk);
            #1;
        end
        tp.stop = 1'b1;
        @(posedge clk); #1;
        tp.stop = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain act=%0d_left req=0_left", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tp.start = 1'b0; tp.stop = 1'b0; tp.cfg_mode = 3'd0;
        tp.cfg_lo = '0; tp.cfg_hi = '0; tp.cfg_dwell = '0;

        // Reset state
        #12;
        chk_now("rst_test_en", {31'd0, tp.test_en}, 32'd0);
        chk_now("rst_code",    tp.test_code,        32'd0);
        chk_now("rst_cnt",     {26'd0, tp.cur_count}, 32'd0);
        chk_now("rst_busy",    {31'd0, tp.busy},    32'd0);
        chk_now("rst_done",    {31'd0, tp.done},    32'd0);
        chk_now("rst_err",     {31'd0, tp.err},     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // RAMP_UP 0..3, dwell 2
        exp_q.push_back(run_rec(32'h0, 6'd0)); exp_q.push_back(run_rec(32'h0, 6'd0));
        exp_q.push_back(run_rec(32'h1, 6'd1)); exp_q.push_back(run_rec(32'h1, 6'd1));
        exp_q.push_back(run_rec(32'h3, 6'd2)); exp_q.push_back(run_rec(32'h3, 6'd2));
        exp_q.push_back(run_rec(32'h7, 6'd3)); exp_q.push_back(run_rec(32'h7, 6'd3));
        exp_q.push_back(done_rec());
        launch(MODE_RAMP_UP, 6'd0, 6'd3, 16'd2, 1'b0);
        drain("ramp_up");

        // RAMP_DOWN lo=40 hi=30 -> 30..32, dwell 1
        exp_q.push_back(run_rec(32'hFFFF_FFFF, 6'd32));
        exp_q.push_back(run_rec(32'h7FFF_FFFF, 6'd31));
        exp_q.push_back(run_rec(32'h3FFF_FFFF, 6'd30));
        exp_q.push_back(done_rec());
        launch(MODE_RAMP_DOWN, 6'd40, 6'd30, 16'd1, 1'b0);
        drain("ramp_down");

        // TRIANGLE 1..3, dwell 1, stop in cycle 6
        exp_q.push_back(run_rec(32'h1, 6'd1)); exp_q.push_back(run_rec(32'h3, 6'd2));
        exp_q.push_back(run_rec(32'h7, 6'd3)); exp_q.push_back(run_rec(32'h3, 6'd2));
        exp_q.push_back(run_rec(32'h1, 6'd1)); exp_q.push_back(run_rec(32'h3, 6'd2));
        exp_q.push_back(done_rec());
        launch(MODE_TRIANGLE, 6'd1, 6'd3, 16'd1, 1'b0);
        stop_at(6);
        drain("triangle");

        // STEP 0/32, dwell 0, start while busy ignored, stop in cycle 6
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(run_rec(32'h0, 6'd0));
            exp_q.push_back(run_rec(32'hFFFF_FFFF, 6'd32));
        end
        exp_q.push_back(done_rec());
        launch(MODE_STEP, 6'd0, 6'd32, 16'd0, 1'b0);
        @(posedge clk); #1;
        tp.start = 1'b1; tp.cfg_mode = MODE_HOLD; tp.cfg_lo = 6'd5; tp.cfg_hi = 6'd5;
        @(posedge clk); #1;
        tp.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tp.stop = 1'b1;
        @(posedge clk); #1;
        tp.stop = 1'b0;
        drain("step");

        // HOLD lo=2, dwell 3, start+stop together accepted, stop in cycle 4
        for (int i = 0; i < 4; i++) exp_q.push_back(run_rec(32'h3, 6'd2));
        exp_q.push_back(done_rec());
        launch(MODE_HOLD, 6'd2, 6'd9, 16'd3, 1'b1);
        stop_at(4);
        drain("hold");

        // Reserved mode -> err pulse only
        exp_q.push_back('{en: 1'b0, code: 32'h0, cnt: 6'd0, busy: 1'b0, done: 1'b0, err: 1'b1});
        launch(3'd6, 6'd1, 6'd2, 16'd1, 1'b0);
        drain("reserved");

        // Async reset mid-dwell, then a fresh run
        for (int i = 0; i < 9; i++) exp_q.push_back(run_rec(32'h0, 6'd0));
        launch(MODE_RAMP_UP, 6'd0, 6'd31, 16'd100, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_now("midrst_test_en", {31'd0, tp.test_en}, 32'd0);
        chk_now("midrst_code",    tp.test_code,        32'd0);
        chk_now("midrst_cnt",     {26'd0, tp.cur_count}, 32'd0);
        chk_now("midrst_busy",    {31'd0, tp.busy},    32'd0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_records act=%0d_left req=0_left", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.push_back(run_rec(32'h7, 6'd3));
        exp_q.push_back(run_rec(32'hF, 6'd4));
        exp_q.push_back(done_rec());
        launch(MODE_RAMP_UP, 6'd3, 6'd4, 16'd1, 1'b0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
